// File: rtl/tn_gpio.sv
// Memory-mapped GPIO controller for the SERV data bus: output/direction registers,
// synchronised input readback, atomic set/clear/toggle and rising-edge interrupt capture.
module tn_gpio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_INV     = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [31:0]      i_adr,
  input  logic [31:0]      i_dat,
  input  logic [3:0]       i_sel,
  input  logic             i_we,
  input  logic             i_cyc,
  output logic [31:0]      o_rdt,
  output logic             o_ack,
  input  logic [WIDTH-1:0] i_gpio_in,
  output logic [WIDTH-1:0] o_gpio_out,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] is_q, is_d;
  logic [WIDTH-1:0] prev_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;

  logic [31:0]      bmask, d;
  logic [WIDTH-1:0] d_w, m_w, rd_w, w1c, sync_last, rise;
  logic             commit, wr;

  // Address bits outside [4:2] and data bits above WIDTH are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{i_adr[31:5], i_adr[1:0], d, bmask};

  always_comb begin
    bmask     = {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};
    d         = i_dat & bmask;
    d_w       = d[WIDTH-1:0];
    m_w       = bmask[WIDTH-1:0];
    commit    = i_cyc & ~ack_q;
    wr        = commit & i_we;
    sync_last = sync_q[SYNC_STAGES-1];
    rise      = sync_last & ~prev_q;
    out_d     = out_q;
    oe_d      = oe_q;
    ie_d      = ie_q;
    w1c       = '0;
    rd_w      = '0;
    case (i_adr[4:2])
      3'd0: begin
        rd_w = out_q;
        if (wr) out_d = (out_q & ~m_w) | d_w;
      end
      3'd1: begin
        rd_w = oe_q;
        if (wr) oe_d = (oe_q & ~m_w) | d_w;
      end
      3'd2: rd_w = sync_last;
      3'd3: if (wr) out_d = out_q | d_w;
      3'd4: if (wr) out_d = out_q & ~d_w;
      3'd5: if (wr) out_d = out_q ^ d_w;
      3'd6: begin
        rd_w = ie_q;
        if (wr) ie_d = (ie_q & ~m_w) | d_w;
      end
      default: begin
        rd_w = is_q;
        if (wr) w1c = d_w;
      end
    endcase
    // A fresh edge outranks a simultaneous write-1-to-clear on the same bit.
    is_d  = (is_q & ~w1c) | rise;
    ack_d = commit;
    rdt_d = '0;
    if (commit) rdt_d[WIDTH-1:0] = rd_w;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      out_q  <= '0;
      oe_q   <= '0;
      ie_q   <= '0;
      is_q   <= '0;
      prev_q <= '0;
      sync_q <= '0;
      ack_q  <= 1'b0;
      rdt_q  <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      ie_q   <= ie_d;
      is_q   <= is_d;
      prev_q <= sync_last;
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpio_in};
      ack_q  <= ack_d;
      rdt_q  <= rdt_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_rdt      = rdt_q;
  assign o_gpio_out = out_q ^ OUT_INV;
  assign o_gpio_oe  = oe_q;
  assign o_irq      = |(is_q & ie_q);

endmodule
